// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling defaults and
// frame-format constants common to both ends of the channel.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_W_DEF     = 8;
    localparam int PARITY_EN_DEF  = 1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Tick index at which a decision is taken, for a given oversampling ratio.
    function automatic int mid_sample(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int last_sample(input int os);
        return os - 1;
    endfunction

    localparam int MID_SAMPLE  = mid_sample(OVERSAMPLE_DEF);
    localparam int LAST_SAMPLE = last_sample(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous serial line; resets to the
// idle (high) level so no spurious start bit is seen after reset.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg[gi] <= IDLE_LEVEL;
                end else if (gi == 0) begin
                    stage_reg[gi] <= d;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start detection, mid-bit sampling, optional
// even parity check and stop-bit framing check, one report per frame.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY_EN  = PARITY_EN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_ENABLE,
    input  logic              Rx_EN,
    input  logic              RxD,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_FERROR,
    output logic              Rx_PERROR
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] MID      = CW'(mid_sample(OVERSAMPLE));
    localparam logic [CW-1:0] LAST     = CW'(last_sample(OVERSAMPLE));
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic              rxs;
    rx_state_t         state_reg;
    logic [CW-1:0]     tick_cnt_reg;
    logic [BW-1:0]     bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bad_reg;
    logic [CW-1:0]     tick_next;

    assign tick_next = tick_cnt_reg + CW'(1);

    uart_rx_sync #(.STAGES(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_bad_reg  <= 1'b0;
            Rx_DATA      <= '0;
            Rx_VALID     <= 1'b0;
            Rx_FERROR    <= 1'b0;
            Rx_PERROR    <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state_reg    <= IDLE;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (sample_ENABLE) begin
                case (state_reg)
                    IDLE: begin
                        if (rxs == START_BIT) begin
                            state_reg    <= START;
                            tick_cnt_reg <= '0;
                        end
                    end
                    // The detection tick is count 0, so the decision lands
                    // on the tick whose incremented count reaches MID.
                    START: begin
                        if (tick_next == MID) begin
                            tick_cnt_reg <= '0;
                            if (rxs == START_BIT) begin
                                state_reg   <= DATA;
                                bit_cnt_reg <= '0;
                                par_bad_reg <= 1'b0;
                                Rx_FERROR   <= 1'b0;
                                Rx_PERROR   <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_next;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_reg == LAST) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rxs, shift_reg[DATA_W-1:1]};
                            if (bit_cnt_reg == LAST_BIT) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + BW'(1);
                            end
                        end else begin
                            tick_cnt_reg <= tick_next;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt_reg == LAST) begin
                            tick_cnt_reg <= '0;
                            par_bad_reg  <= (^shift_reg) ^ rxs;
                            state_reg    <= STOP;
                        end else begin
                            tick_cnt_reg <= tick_next;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_reg == LAST) begin
                            tick_cnt_reg <= '0;
                            Rx_DATA      <= shift_reg;
                            Rx_FERROR    <= (rxs != STOP_BIT);
                            Rx_PERROR    <= par_bad_reg;
                            Rx_VALID     <= (rxs == STOP_BIT) && !par_bad_reg;
                            state_reg    <= (rxs == STOP_BIT) ? IDLE : WAIT_HIGH;
                        end else begin
                            tick_cnt_reg <= tick_next;
                        end
                    end
                    // A held-low line must return high before a new start.
                    WAIT_HIGH: begin
                        if (rxs == IDLE_LEVEL) begin
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected reports,
// a monitor pops and compares whenever the receiver reports a frame.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_ENABLE = 1'b1;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;

    always #5 clk = ~clk;

    uart_receiver #(.DATA_W(8), .OVERSAMPLE(16), .PARITY_EN(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .RxD           (RxD),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_FERROR     (Rx_FERROR),
        .Rx_PERROR     (Rx_PERROR)
    );

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
        int         start_cyc;
        int         lat_min;
        int         lat_max;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   div_mode = 1'b0;
    int   div_cnt = 0;

    always @(posedge clk) cyc++;

    // Tick generator: every clk normally, every 3rd clk in slow mode.
    always @(negedge clk) begin
        if (div_mode) begin
            div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
            sample_ENABLE = (div_cnt == 0);
        end else begin
            sample_ENABLE = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a frame report is a VALID pulse or a fresh error flag.
    logic prev_err = 1'b0;
    logic prev_valid = 1'b0;
    exp_t mon_e;
    int   mon_lat;
    always @(negedge clk) begin
        if (Rx_VALID || ((Rx_FERROR || Rx_PERROR) && !prev_err)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got data=%0h valid=%0b ferr=%0b perr=%0b, required no frame (cyc %0d)",
                         Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, cyc);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_lat = cyc - mon_e.start_cyc;
                $display("frame: data=%0h valid=%0b ferr=%0b perr=%0b latency=%0d", Rx_DATA, Rx_VALID,
                         Rx_FERROR, Rx_PERROR, mon_lat);
                check("rx_data", Rx_DATA, mon_e.data);
                check("rx_valid", Rx_VALID, mon_e.valid);
                check("rx_ferror", Rx_FERROR, mon_e.ferr);
                check("rx_perror", Rx_PERROR, mon_e.perr);
                total++;
                if (mon_lat < mon_e.lat_min || mon_lat > mon_e.lat_max) begin
                    bad++;
                    $display("FAIL latency: got %0d required %0d..%0d", mon_lat, mon_e.lat_min, mon_e.lat_max);
                end
            end
        end
        if (prev_valid) check("valid_pulse_width", Rx_VALID, 0);
        prev_err   = Rx_FERROR || Rx_PERROR;
        prev_valid = Rx_VALID;
    end

    // Drives one frame starting at the current negedge. cut>0 stops after
    // that many clks with the line returned high.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bclk,
                              input int cut, input bit push, input logic ev, input logic ef,
                              input logic ep, input int lmin, input int lmax);
        logic [10:0] bits;
        exp_t        e;
        int          n;
        bits = {stp, par, d, 1'b0};
        if (push) begin
            e.data = d; e.valid = ev; e.ferr = ef; e.perr = ep;
            e.start_cyc = cyc; e.lat_min = lmin; e.lat_max = lmax;
            sb_q.push_back(e);
        end
        n = 0;
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < bclk; k++) begin
                if (cut != 0 && n >= cut) begin
                    RxD = 1'b1;
                    return;
                end
                RxD = bits[b];
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, Rx_DATA, 0);
        check({tag, "_valid"}, Rx_VALID, 0);
        check({tag, "_ferr"}, Rx_FERROR, 0);
        check({tag, "_perr"}, Rx_PERROR, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        Rx_EN = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        idle(20);

        // Good frame, correct even parity.
        send_frame(8'hA5, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
        idle(10);

        // Parity error: 8'h01 needs parity 1.
        send_frame(8'h01, 1'b0, 1'b1, 16, 0, 1, 1'b0, 1'b0, 1'b1, 170, 170);
        idle(10);
        check("perr_held", Rx_PERROR, 1);

        // Framing error then a held-low break.
        fork
            send_frame(8'h3C, 1'b0, 1'b0, 16, 0, 1, 1'b0, 1'b1, 1'b0, 170, 170);
            begin
                repeat (40) @(negedge clk);
                check("perr_cleared_at_start", Rx_PERROR, 0);
            end
        join
        repeat (40) @(negedge clk);
        check("ferr_held_in_break", Rx_FERROR, 1);
        idle(20);
        fork
            send_frame(8'h55, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
            begin
                repeat (40) @(negedge clk);
                check("ferr_cleared_at_start", Rx_FERROR, 0);
            end
        join
        idle(10);

        // Short glitch on idle line.
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("glitch_data_held", Rx_DATA, 8'h55);
        check("glitch_ferr", Rx_FERROR, 0);
        check("glitch_perr", Rx_PERROR, 0);

        // Back-to-back frames, no idle gap.
        send_frame(8'hFF, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
        send_frame(8'h00, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
        idle(10);

        // Reset during data bit 3.
        send_frame(8'h81, 1'b0, 1'b1, 16, 72, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("midframe_reset");
        reset = 1'b0;
        idle(20);
        send_frame(8'h81, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
        idle(10);

        // Receiver disable during data bit 3.
        send_frame(8'h81, 1'b0, 1'b1, 16, 72, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        Rx_EN = 1'b0;
        repeat (2) @(negedge clk);
        Rx_EN = 1'b1;
        idle(200);
        check("abort_data_held", Rx_DATA, 8'h81);
        send_frame(8'h81, 1'b0, 1'b1, 16, 0, 1, 1'b1, 1'b0, 1'b0, 170, 170);
        idle(10);

        // One tick every 3 clks: 167 ticks plus up to 2 clks of tick phase.
        div_mode = 1'b1;
        idle(12);
        send_frame(8'h81, 1'b0, 1'b1, 48, 0, 1, 1'b1, 1'b0, 1'b0, 504, 506);
        idle(30);
        div_mode = 1'b0;
        idle(20);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
